munch_sequencer: RTL and testbench

- Frame-level controller for the munching-squares VGA datapath. Replaces the free-running frame counter that is clocked directly off vsync.
- Samples vsync in the pixel-clock domain and produces a frame counter plus trail offsets. Handles pause and single-step, speed division and direction.
- Schedules scene changes, either automatically or from a manual selection. Each change runs as a brightness cross-fade.
- Outputs feed the colour logic that sits between hvsync_generator and uo_out.

---
 rtl/munch_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_munch_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/munch_sequencer.sv
// Frame-level sequencer for the munching-squares datapath: frame counter with trails,
// pause/single-step, speed division, direction and scene cross-fades.
module munch_sequencer #(
  parameter int unsigned FRAME_W      = 9,
  parameter int unsigned TRAIL_GAP    = 5,
  parameter int unsigned SCENE_FRAMES = 512,
  parameter bit          VSYNC_ACT    = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               pause,
  input  logic               step,
  input  logic [1:0]         speed,
  input  logic               dir,
  input  logic               auto_en,
  input  logic [1:0]         scene_sel,
  output logic [FRAME_W-1:0] frame_no,
  output logic [FRAME_W-1:0] trail1,
  output logic [FRAME_W-1:0] trail2,
  output logic [1:0]         scene,
  output logic [1:0]         brightness,
  output logic               frame_tick,
  output logic               scene_change
);

  localparam logic [15:0]        TimerLast = 16'(SCENE_FRAMES - 1);
  localparam logic [FRAME_W-1:0] Gap1      = FRAME_W'(TRAIL_GAP);
  localparam logic [FRAME_W-1:0] Gap2      = FRAME_W'(2 * TRAIL_GAP);
  localparam logic [FRAME_W-1:0] FrameOne  = FRAME_W'(1);

  typedef enum logic [1:0] {StRun, StHold, StXfade} state_e;

  // Two-flop synchronisers for all asynchronous pin inputs, packed together.
  logic [7:0] sync1_q, sync2_q;
  logic       pause_s, step_s, dir_s, auto_en_s;
  logic [1:0] speed_s, scene_sel_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {pause, step, speed, dir, auto_en, scene_sel};
      sync2_q <= sync1_q;
    end
  end

  assign {pause_s, step_s, speed_s, dir_s, auto_en_s, scene_sel_s} = sync2_q;

  state_e             state_q, state_d;
  logic               vs_prev_q;
  logic               step_prev_q;
  logic               step_pending_q, step_pending_d;
  logic [2:0]         div_q, div_d;
  logic [15:0]        timer_q, timer_d;
  logic [2:0]         fade_q, fade_d;
  logic [1:0]         target_q, target_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [1:0]         scene_q, scene_d;
  logic [1:0]         bright_q, bright_d;
  logic               tick_q, tick_d;
  logic               change_q, change_d;

  logic               frame_edge;
  logic               step_rise;
  logic [2:0]         div_limit;
  logic               div_hit;
  logic [FRAME_W-1:0] frame_adv;
  logic               scene_req;
  logic [1:0]         req_target;

  assign frame_edge = (vsync == VSYNC_ACT) && (vs_prev_q != VSYNC_ACT);
  assign step_rise  = step_s && !step_prev_q;
  assign div_limit  = 3'((4'd1 << speed_s) - 4'd1);
  // A speed drop can leave div above the new limit; treat that as a match.
  assign div_hit    = (div_q >= div_limit);
  assign frame_adv  = dir_s ? (frame_q - FrameOne) : (frame_q + FrameOne);

  always_comb begin
    if (auto_en_s) begin
      scene_req  = (timer_q == TimerLast);
      req_target = scene_q + 2'd1;
    end else begin
      scene_req  = (scene_sel_s != scene_q);
      req_target = scene_sel_s;
    end
  end

  always_comb begin
    state_d        = state_q;
    step_pending_d = step_pending_q;
    div_d          = div_q;
    timer_d        = timer_q;
    fade_d         = fade_q;
    target_d       = target_q;
    frame_d        = frame_q;
    scene_d        = scene_q;
    bright_d       = bright_q;
    tick_d         = frame_edge;
    change_d       = 1'b0;

    case (state_q)
      StRun: begin
        if (frame_edge) begin
          timer_d = timer_q + 16'd1;
          if (pause_s) begin
            state_d = StHold;
          end else begin
            if (scene_req) begin
              state_d  = StXfade;
              target_d = req_target;
              bright_d = 2'd2;
              fade_d   = 3'd0;
            end
            if (div_hit) begin
              frame_d = frame_adv;
              div_d   = 3'd0;
            end else begin
              div_d = div_q + 3'd1;
            end
          end
        end
      end
      StHold: begin
        if (frame_edge) begin
          if (step_pending_q) begin
            frame_d        = frame_adv;
            step_pending_d = 1'b0;
          end
          if (!pause_s) begin
            state_d = StRun;
          end
        end
      end
      StXfade: begin
        if (frame_edge) begin
          if (div_hit) begin
            frame_d = frame_adv;
            div_d   = 3'd0;
          end else begin
            div_d = div_q + 3'd1;
          end
          fade_d = fade_q + 3'd1;
          // fade_q counts edges after entry: brightness 1, 0, 1, 2, then 3 and exit.
          case (fade_q)
            3'd0: bright_d = 2'd1;
            3'd1: begin
              bright_d = 2'd0;
              scene_d  = target_q;
              change_d = 1'b1;
            end
            3'd2: bright_d = 2'd1;
            3'd3: bright_d = 2'd2;
            default: begin
              bright_d = 2'd3;
              state_d  = StRun;
              timer_d  = 16'd0;
            end
          endcase
        end
      end
      default: state_d = StRun;
    endcase

    if (state_q == StHold && step_rise) begin
      step_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StRun;
      vs_prev_q      <= !VSYNC_ACT;
      step_prev_q    <= 1'b0;
      step_pending_q <= 1'b0;
      div_q          <= 3'd0;
      timer_q        <= 16'd0;
      fade_q         <= 3'd0;
      target_q       <= 2'd0;
      frame_q        <= '0;
      scene_q        <= 2'd0;
      bright_q       <= 2'd3;
      tick_q         <= 1'b0;
      change_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      vs_prev_q      <= vsync;
      step_prev_q    <= step_s;
      step_pending_q <= step_pending_d;
      div_q          <= div_d;
      timer_q        <= timer_d;
      fade_q         <= fade_d;
      target_q       <= target_d;
      frame_q        <= frame_d;
      scene_q        <= scene_d;
      bright_q       <= bright_d;
      tick_q         <= tick_d;
      change_q       <= change_d;
    end
  end

  always_comb begin
    if (dir_s) begin
      trail1 = frame_q + Gap1;
      trail2 = frame_q + Gap2;
    end else begin
      trail1 = frame_q - Gap1;
      trail2 = frame_q - Gap2;
    end
  end

  assign frame_no     = frame_q;
  assign scene        = scene_q;
  assign brightness   = bright_q;
  assign frame_tick   = tick_q;
  assign scene_change = change_q;

endmodule

// File: tb/tb_munch_sequencer.sv
// Scoreboard bench for munch_sequencer: each issued vsync edge queues its expected
// outputs; a monitor compares them whenever frame_tick is presented.
module tb_munch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       pause;
  logic       step;
  logic [1:0] speed;
  logic       dir;
  logic       auto_en;
  logic [1:0] scene_sel;
  logic [8:0] frame_no, trail1, trail2;
  logic [1:0] scene, brightness;
  logic       frame_tick, scene_change;

  munch_sequencer #(
    .FRAME_W     (9),
    .TRAIL_GAP   (5),
    .SCENE_FRAMES(4),
    .VSYNC_ACT   (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .pause       (pause),
    .step        (step),
    .speed       (speed),
    .dir         (dir),
    .auto_en     (auto_en),
    .scene_sel   (scene_sel),
    .frame_no    (frame_no),
    .trail1      (trail1),
    .trail2      (trail2),
    .scene       (scene),
    .brightness  (brightness),
    .frame_tick  (frame_tick),
    .scene_change(scene_change)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fno;
    int t1;
    int t2;
    int sc;
    int br;
    int sch;
  } exp_t;

  exp_t exp_q[$];
  exp_t got_e;
  int   total  = 0;
  int   bad    = 0;
  int   ticks  = 0;
  int   pushed = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // One vsync pulse; the expected post-edge outputs are queued just before the edge.
  task automatic frame(input int fno, input int sc, input int br, input int sch);
    exp_t e;
    e.fno = fno;
    e.t1  = dir ? (fno + 5) % 512 : (fno - 5 + 512) % 512;
    e.t2  = dir ? (fno + 10) % 512 : (fno - 10 + 512) % 512;
    e.sc  = sc;
    e.br  = br;
    e.sch = sch;
    repeat (6) @(negedge clk);
    exp_q.push_back(e);
    pushed++;
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    repeat (4) @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_tick) begin
        ticks++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_tick: got tick with frame_no %0d want no tick", frame_no);
        end else begin
          got_e = exp_q.pop_front();
          chk("frame_no", frame_no, got_e.fno);
          chk("trail1", trail1, got_e.t1);
          chk("trail2", trail2, got_e.t2);
          chk("scene", scene, got_e.sc);
          chk("brightness", brightness, got_e.br);
          chk("scene_change", scene_change, got_e.sch);
        end
      end else begin
        chk("scene_change_idle", scene_change, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; vsync = 1'b1; pause = 1'b0; step = 1'b0; speed = 2'd0;
    dir = 1'b0; auto_en = 1'b0; scene_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_frame_no", frame_no, 0);
    chk("rst_scene", scene, 0);
    chk("rst_brightness", brightness, 3);
    chk("rst_frame_tick", frame_tick, 0);
    chk("rst_trail1", trail1, 507);
    chk("rst_trail2", trail2, 502);
    rst_n = 1'b1;

    // Basic count-up.
    frame(1, 0, 3, 0); frame(2, 0, 3, 0); frame(3, 0, 3, 0);
    // Divide by 4.
    speed = 2'd2;
    frame(3, 0, 3, 0); frame(3, 0, 3, 0); frame(3, 0, 3, 0); frame(4, 0, 3, 0);
    // Count down through wrap.
    speed = 2'd0; dir = 1'b1;
    frame(3, 0, 3, 0); frame(2, 0, 3, 0); frame(1, 0, 3, 0); frame(0, 0, 3, 0);
    frame(511, 0, 3, 0);
    // Pause and single-step.
    dir = 1'b0; pause = 1'b1;
    frame(511, 0, 3, 0);
    pulse_step();
    frame(0, 0, 3, 0);
    frame(0, 0, 3, 0);
    pulse_step();
    frame(1, 0, 3, 0);
    pulse_step();
    pause = 1'b0;
    frame(2, 0, 3, 0);
    frame(3, 0, 3, 0);
    // Manual cross-fade to scene 2; mid-fade selection change must be ignored.
    scene_sel = 2'd2;
    frame(4, 0, 2, 0); frame(5, 0, 1, 0);
    scene_sel = 2'd1;
    frame(6, 2, 0, 1); frame(7, 2, 1, 0);
    scene_sel = 2'd2;
    frame(8, 2, 2, 0); frame(9, 2, 3, 0); frame(10, 2, 3, 0);
    // Automatic rotation every 4 RUN edges, wrapping 3 -> 0.
    auto_en = 1'b1;
    frame(11, 2, 3, 0); frame(12, 2, 3, 0);
    frame(13, 2, 2, 0); frame(14, 2, 1, 0); frame(15, 3, 0, 1); frame(16, 3, 1, 0);
    frame(17, 3, 2, 0); frame(18, 3, 3, 0);
    frame(19, 3, 3, 0); frame(20, 3, 3, 0); frame(21, 3, 3, 0);
    frame(22, 3, 2, 0); frame(23, 3, 1, 0); frame(24, 0, 0, 1); frame(25, 0, 1, 0);

    // Asynchronous reset in the middle of the fade.
    chk("queue_drained_before_reset", exp_q.size(), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_frame_no", frame_no, 0);
    chk("arst_scene", scene, 0);
    chk("arst_brightness", brightness, 3);
    chk("arst_frame_tick", frame_tick, 0);
    auto_en = 1'b0; scene_sel = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame(1, 0, 3, 0);
    repeat (4) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    chk("tick_count", ticks, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
